// File: rtl/oven_time_entry.sv
// Oven front-panel time entry: debounces four buttons, builds a BCD MM:SS cook time
// and runs the load/stop handshake with the countdown. Define AUTO_REPEAT_EN for held-button auto-repeat.
module oven_time_entry #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_min,
   input  logic       btn_sec,
   input  logic       btn_start,
   input  logic       btn_clear,
   input  logic       timer_done,
   output logic [2:0] set_m1,
   output logic [3:0] set_m0,
   output logic [2:0] set_s1,
   output logic [3:0] set_s0,
   output logic       load,
   output logic       stop,
   output logic       editing,
   output logic       running
);

   localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int B_MIN   = 0;
   localparam int B_SEC   = 1;
   localparam int B_START = 2;
   localparam int B_CLEAR = 3;

   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
      $error("oven_time_entry: counter parameters must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, EDIT, LOAD, RUN} state_t;

   typedef struct packed {
      logic [2:0] m1;
      logic [3:0] m0;
      logic [2:0] s1;
      logic [3:0] s0;
   } bcd_time_t;

   state_t    state, state_next;
   bcd_time_t digits, digits_next;
   logic      load_next, stop_next;

   logic [3:0]    raw, sync1, sync2, db, db_d, press;
   logic [DW-1:0] db_cnt [4];
   logic [1:0]    rep_fire;
   logic          ev_min, ev_sec;
   logic          do_clear, do_start, do_min, do_sec;

   assign raw = {btn_clear, btn_start, btn_sec, btn_min};

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the small debounce counter array is reset explicitly; it is state, not a storage memory.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         db    <= '0;
         db_d  <= '0;
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         db_d  <= db;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               db[i]     <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DW'(1);
            end
         end
      end
   end

   assign press = db & ~db_d;

`ifdef AUTO_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW      = $clog2(REP_MAX + 1);

   logic [RW-1:0] rep_cnt [2];
   logic [1:0]    rep_phase;
   logic          rep_allowed;

   assign rep_allowed = (state == IDLE) || (state == EDIT);

   // A zero count means "not armed"; the first fire waits REPEAT_DELAY, later ones REPEAT_PERIOD.
   always_comb begin
      rep_fire = '0;
      for (int i = 0; i < 2; i++) begin
         rep_fire[i] = db[i] && rep_allowed && (rep_cnt[i] != '0) &&
                       (rep_cnt[i] == (rep_phase[i] ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY)));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_phase <= '0;
         for (int i = 0; i < 2; i++) rep_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!db[i] || press[B_CLEAR] || !rep_allowed) begin
               rep_cnt[i]   <= '0;
               rep_phase[i] <= 1'b0;
            end else if (press[i]) begin
               rep_cnt[i]   <= RW'(1);
               rep_phase[i] <= 1'b0;
            end else if (rep_fire[i]) begin
               rep_cnt[i]   <= RW'(1);
               rep_phase[i] <= 1'b1;
            end else if (rep_cnt[i] != '0) begin
               rep_cnt[i] <= rep_cnt[i] + RW'(1);
            end
         end
      end
   end
`else
   assign rep_fire = 2'b00;
`endif

   assign ev_min = press[B_MIN] | rep_fire[B_MIN];
   assign ev_sec = press[B_SEC] | rep_fire[B_SEC];

   // Only the highest-priority event acts: clear > start > min > sec.
   assign do_clear = press[B_CLEAR];
   assign do_start = press[B_START] & ~press[B_CLEAR];
   assign do_min   = ev_min & ~press[B_CLEAR] & ~press[B_START];
   assign do_sec   = ev_sec & ~press[B_CLEAR] & ~press[B_START] & ~ev_min;

   function automatic bcd_time_t add_min(input bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.m1 == 3'd5 && t.m0 == 4'd9) return t;
      if (t.m0 == 4'd9) begin
         r.m0 = '0;
         r.m1 = t.m1 + 3'd1;
      end else begin
         r.m0 = t.m0 + 4'd1;
      end
      return r;
   endfunction

   function automatic bcd_time_t add_sec(input bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.s0 != 4'd9) begin
         r.s0 = t.s0 + 4'd1;
      end else if (t.s1 != 3'd5) begin
         r.s0 = '0;
         r.s1 = t.s1 + 3'd1;
      end else if (!(t.m1 == 3'd5 && t.m0 == 4'd9)) begin
         r    = add_min(t);
         r.s1 = '0;
         r.s0 = '0;
      end
      return r;
   endfunction

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_next  = state;
      digits_next = digits;
      load_next   = 1'b0;
      stop_next   = 1'b0;
      unique case (state)
         IDLE: begin
            if (do_min || do_sec) begin
               digits_next = do_min ? add_min(digits) : add_sec(digits);
               state_next  = EDIT;
            end
         end
         EDIT: begin
            if (do_clear) begin
               digits_next = '0;
               state_next  = IDLE;
            end else if (do_start) begin
               load_next  = 1'b1;
               state_next = LOAD;
            end else if (do_min) begin
               digits_next = add_min(digits);
            end else if (do_sec) begin
               digits_next = add_sec(digits);
            end
         end
         LOAD: begin
            state_next = RUN;
         end
         RUN: begin
            if (timer_done) begin
               digits_next = '0;
               state_next  = IDLE;
            end else if (do_clear) begin
               digits_next = '0;
               stop_next   = 1'b1;
               state_next  = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         digits  <= '0;
         load    <= 1'b0;
         stop    <= 1'b0;
         editing <= 1'b0;
         running <= 1'b0;
      end else begin
         state   <= state_next;
         digits  <= digits_next;
         load    <= load_next;
         stop    <= stop_next;
         editing <= (state_next == EDIT);
         running <= (state_next == RUN);
      end
   end

   assign set_m1 = digits.m1;
   assign set_m0 = digits.m0;
   assign set_s1 = digits.s1;
   assign set_s0 = digits.s0;

endmodule

// File: tb/tb_oven_time_entry.sv
// Scoreboard bench for oven_time_entry: a seconds-based model pushes expected output states,
// a negedge monitor pops and compares each time the DUT outputs change.
module tb_oven_time_entry;

   localparam int D  = 4;
   localparam int RD = 20;
   localparam int RP = 5;

   localparam int K_SEC = 0, K_MIN = 1, K_START = 2, K_CLEAR = 3,
                  K_DONE = 4, K_CLEAR_DONE = 5, K_CLEAR_START = 6;
   localparam int M_IDLE = 0, M_EDIT = 1, M_RUN = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       btn_min = 1'b0, btn_sec = 1'b0, btn_start = 1'b0, btn_clear = 1'b0;
   logic       timer_done = 1'b0;
   logic [2:0] set_m1, set_s1;
   logic [3:0] set_m0, set_s0;
   logic       load, stop, editing, running;

   oven_time_entry #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_min   (btn_min),
      .btn_sec   (btn_sec),
      .btn_start (btn_start),
      .btn_clear (btn_clear),
      .timer_done(timer_done),
      .set_m1    (set_m1),
      .set_m0    (set_m0),
      .set_s1    (set_s1),
      .set_s0    (set_s0),
      .load      (load),
      .stop      (stop),
      .editing   (editing),
      .running   (running)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] m1;
      logic [3:0] m0;
      logic [2:0] s1;
      logic [3:0] s0;
      logic       load;
      logic       stop;
      logic       editing;
      logic       running;
   } obs_t;

   obs_t exp_q[$];
   int   tests = 0, fails = 0;
   int   model_t = 0, mode = M_IDLE;
   int   exp_loads = 0, exp_stops = 0, seen_loads = 0, seen_stops = 0;
   bit   mon_en = 1'b0;

   function automatic obs_t mk(input int t, input bit ld, input bit st, input bit ed, input bit rn);
      obs_t o;
      int   mm, ss;
      mm = t / 60;
      ss = t % 60;
      o.m1 = 3'(mm / 10);
      o.m0 = 4'(mm % 10);
      o.s1 = 3'(ss / 10);
      o.s0 = 4'(ss % 10);
      o.load = ld;
      o.stop = st;
      o.editing = ed;
      o.running = rn;
      return o;
   endfunction

   function automatic obs_t observe();
      return {set_m1, set_m0, set_s1, set_s0, load, stop, editing, running};
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("%0d%0d:%0d%0d ld=%0b st=%0b ed=%0b rn=%0b",
                       o.m1, o.m0, o.s1, o.s0, o.load, o.stop, o.editing, o.running);
   endfunction

   function automatic obs_t model_now();
      return mk(model_t, 1'b0, 1'b0, mode == M_EDIT, mode == M_RUN);
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %s, want %s", name, fmt(act), fmt(exp));
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Monitor: every change of the observable outputs must match the next expected state.
   initial begin
      obs_t prev, cur;
      wait (mon_en);
      prev = observe();
      forever begin
         @(negedge clk);
         cur = observe();
         if (cur.load) seen_loads++;
         if (cur.stop) seen_stops++;
         if (cur != prev) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_output: got %s, want no change", fmt(cur));
            end else begin
               check("output_event", cur, exp_q.pop_front());
            end
         end
         prev = cur;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want $finish before 50000 cycles");
      $fatal(1, "watchdog expired");
   end

   function automatic int inc_sec(input int t);
      return (t < 3599) ? t + 1 : t;
   endfunction

   function automatic int inc_min(input int t);
      return (t / 60 < 59) ? t + 60 : t;
   endfunction

   task automatic model_step(input int kind);
      bit clr, done, inc;
      int nt;
      clr  = (kind == K_CLEAR) || (kind == K_CLEAR_DONE) || (kind == K_CLEAR_START);
      done = (kind == K_DONE) || (kind == K_CLEAR_DONE);
      inc  = (kind == K_SEC) || (kind == K_MIN);
      nt   = (kind == K_SEC) ? inc_sec(model_t) : inc_min(model_t);
      case (mode)
         M_IDLE: if (inc) begin
            model_t = nt;
            mode = M_EDIT;
            exp_q.push_back(mk(model_t, 0, 0, 1, 0));
         end
         M_EDIT: begin
            if (clr) begin
               model_t = 0;
               mode = M_IDLE;
               exp_q.push_back(mk(0, 0, 0, 0, 0));
            end else if (kind == K_START) begin
               exp_q.push_back(mk(model_t, 1, 0, 0, 0));
               exp_q.push_back(mk(model_t, 0, 0, 0, 1));
               exp_loads++;
               mode = M_RUN;
            end else if (inc && nt != model_t) begin
               model_t = nt;
               exp_q.push_back(mk(model_t, 0, 0, 1, 0));
            end
         end
         default: begin
            if (done) begin
               exp_q.push_back(mk(0, 0, 0, 0, 0));
               model_t = 0;
               mode = M_IDLE;
            end else if (clr) begin
               exp_q.push_back(mk(0, 0, 1, 0, 0));
               exp_q.push_back(mk(0, 0, 0, 0, 0));
               exp_stops++;
               model_t = 0;
               mode = M_IDLE;
            end
         end
      endcase
   endtask

   // Raw buttons go high just after an edge; the press acts D+3 edges later.
   task automatic press_btns(input logic [3:0] mask, input bit with_done);
      @(posedge clk); #1;
      {btn_clear, btn_start, btn_sec, btn_min} = mask;
      repeat (D + 2) @(posedge clk);
      #1 timer_done = with_done;
      @(posedge clk); #1;
      timer_done = 1'b0;
      repeat (2) @(posedge clk);
      #1 {btn_clear, btn_start, btn_sec, btn_min} = 4'b0000;
      repeat (D + 4) @(posedge clk);
   endtask

   task automatic do_action(input int kind);
      model_step(kind);
      case (kind)
         K_SEC:         press_btns(4'b0010, 1'b0);
         K_MIN:         press_btns(4'b0001, 1'b0);
         K_START:       press_btns(4'b0100, 1'b0);
         K_CLEAR:       press_btns(4'b1000, 1'b0);
         K_CLEAR_DONE:  press_btns(4'b1000, 1'b1);
         K_CLEAR_START: press_btns(4'b1100, 1'b0);
         default: begin
            @(posedge clk); #1 timer_done = 1'b1;
            @(posedge clk); #1 timer_done = 1'b0;
            repeat (2) @(posedge clk);
         end
      endcase
      #1;
      check("settled_outputs", observe(), model_now());
      check_int("queue_drained", exp_q.size(), 0);
   endtask

   task automatic repeat_n(input int kind, input int n);
      for (int i = 0; i < n; i++) do_action(kind);
   endtask

   initial begin
      int lat, hold, n_rep, r;

      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", observe(), mk(0, 0, 0, 0, 0));
      rst_n = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);

      // Bouncing btn_sec: only the final stable rise counts.
      exp_q.push_back(mk(1, 0, 0, 1, 0));
      model_t = 1;
      mode = M_EDIT;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         btn_sec = (i % 2 == 0);
         repeat (2) @(posedge clk);
         #1;
      end
      btn_sec = 1'b1;
      lat = 0;
      while (set_s0 == 4'd0 && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check_int("debounce_latency", lat, D + 3);
      repeat (3) @(posedge clk);
      #1 btn_sec = 1'b0;
      repeat (D + 4) @(posedge clk);
      #1;
      check("debounce_result", observe(), mk(1, 0, 0, 1, 0));
      do_action(K_CLEAR);

      // Carries and saturation.
      repeat_n(K_SEC, 51);
      repeat_n(K_SEC, 9);
      check("carry_to_01_00", observe(), mk(60, 0, 0, 1, 0));
      do_action(K_CLEAR);
      repeat_n(K_MIN, 59);
      check("min_to_59_00", observe(), mk(3540, 0, 0, 1, 0));
      do_action(K_MIN);
      check("min_saturate", observe(), mk(3540, 0, 0, 1, 0));
      repeat_n(K_SEC, 59);
      do_action(K_SEC);
      check("sec_saturate", observe(), mk(3599, 0, 0, 1, 0));
      do_action(K_MIN);
      do_action(K_CLEAR);

      // Start handshake, RUN ignores min, clear cancels with stop.
      repeat_n(K_MIN, 2);
      repeat_n(K_SEC, 30);
      do_action(K_START);
      check("run_02_30", observe(), mk(150, 0, 0, 0, 1));
      do_action(K_MIN);
      check("min_in_run", observe(), mk(150, 0, 0, 0, 1));
      do_action(K_CLEAR);

      // timer_done ends RUN without stop; coincident clear still gives no stop.
      do_action(K_SEC);
      do_action(K_START);
      do_action(K_DONE);
      do_action(K_SEC);
      do_action(K_START);
      do_action(K_CLEAR_DONE);

      // Clear beats start in EDIT.
      do_action(K_MIN);
      do_action(K_CLEAR_START);
      check("clear_beats_start", observe(), mk(0, 0, 0, 0, 0));

      // Held sec button: one press, plus auto-repeats when enabled.
      hold = 34;
      n_rep = 0;
`ifdef AUTO_REPEAT_EN
      for (int o = RD; o < hold; o += RP) n_rep++;
`endif
      for (int k = 0; k <= n_rep; k++) exp_q.push_back(mk(k + 1, 0, 0, 1, 0));
      model_t = n_rep + 1;
      mode = M_EDIT;
      @(posedge clk); #1 btn_sec = 1'b1;
      repeat (hold) @(posedge clk);
      #1 btn_sec = 1'b0;
      repeat (D + 4) @(posedge clk);
      #1;
      check("hold_sec", observe(), model_now());
      do_action(K_CLEAR);

      // Random mix against the model.
      for (int i = 0; i < 80; i++) begin
         r = $urandom_range(0, 99);
         if (r < 35)      do_action(K_SEC);
         else if (r < 60) do_action(K_MIN);
         else if (r < 72) do_action(K_START);
         else if (r < 82) do_action(K_CLEAR);
         else if (r < 90) do_action(K_DONE);
         else if (r < 95) do_action(K_CLEAR_DONE);
         else             do_action(K_CLEAR_START);
      end

      // Reset during LOAD drops everything immediately.
      if (mode == M_RUN) do_action(K_CLEAR);
      if (mode == M_IDLE) do_action(K_SEC);
      do_action(K_SEC);
      exp_q.push_back(mk(model_t, 1, 0, 0, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      exp_loads++;
      @(posedge clk); #1 btn_start = 1'b1;
      repeat (D + 3) @(posedge clk);
      @(negedge clk); #1 rst_n = 1'b0;
      #1;
      check_int("load_drops_on_reset", int'(load), 0);
      check("reset_in_load", observe(), mk(0, 0, 0, 0, 0));
      btn_start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      model_t = 0;
      mode = M_IDLE;
      repeat (D + 4) @(posedge clk);
      #1;
      check("after_reset", observe(), model_now());
      do_action(K_START);

      check_int("final_queue_empty", exp_q.size(), 0);
      check_int("load_pulse_cycles", seen_loads, exp_loads);
      check_int("stop_pulse_cycles", seen_stops, exp_stops);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
